// File: rtl/key_stream_loader.sv
// Serial key loader: shifts a KEY_W-bit key in LSB first, checks an even-parity
// beat, then arms a stable parallel key and releases the downstream FSM reset.
module key_stream_loader #(
  parameter int KEY_W    = 8,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             fsm_rst,
  output logic             err,
  output logic             locked,
  output logic             busy
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_ARMED,
    S_ERROR,
    S_LOCKED
  } state_t;

  state_t             r_state,     w_state_next;
  logic [CNT_W-1:0]   r_count,     w_count_next;
  logic [FAIL_W-1:0]  r_fail,      w_fail_next;
  logic [KEY_W-1:0]   r_shadow,    w_shadow_next;
  logic [KEY_W-1:0]   r_keyinput,  w_keyinput_next;
  logic               r_key_valid, w_key_valid_next;
  logic               r_fsm_rst,   w_fsm_rst_next;
  logic               r_err,       w_err_next;
  logic               r_locked,    w_locked_next;
  logic               r_busy,      w_busy_next;
  logic               r_s_ready,   w_s_ready_next;

  logic               w_accept;
  logic               w_parity;
  logic [KEY_W-1:0]   w_bit_mask;
  logic [FAIL_W-1:0]  w_fail_inc;

  assign w_accept   = s_valid & r_s_ready;
  assign w_parity   = (^r_shadow) ^ s_data;
  assign w_bit_mask = KEY_W'(1) << r_count;
  // Fail counter saturates so a long run of bad loads cannot wrap past MAX_FAIL.
  assign w_fail_inc = (r_fail == FAIL_W'(MAX_FAIL)) ? r_fail : r_fail + FAIL_W'(1);

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves it unassigned (no latch).
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_fail_next      = r_fail;
    w_shadow_next    = r_shadow;
    w_keyinput_next  = r_keyinput;
    w_key_valid_next = r_key_valid;
    w_fsm_rst_next   = r_fsm_rst;
    w_err_next       = r_err;
    w_locked_next    = r_locked;
    w_busy_next      = r_busy;
    w_s_ready_next   = r_s_ready;

    unique case (r_state)
      S_IDLE, S_ARMED, S_ERROR: begin
        if (start) begin
          w_state_next     = S_SHIFT;
          w_count_next     = '0;
          w_shadow_next    = '0;
          w_err_next       = 1'b0;
          w_key_valid_next = 1'b0;
          w_fsm_rst_next   = 1'b1;
          w_busy_next      = 1'b1;
          w_s_ready_next   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_accept) begin
          w_shadow_next = s_data ? (r_shadow | w_bit_mask) : r_shadow;
          w_count_next  = r_count + CNT_W'(1);
          if (r_count == CNT_W'(KEY_W - 1)) w_state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_accept) begin
          w_busy_next    = 1'b0;
          w_s_ready_next = 1'b0;
          if (!w_parity) begin
            w_state_next     = S_ARMED;
            w_keyinput_next  = r_shadow;
            w_key_valid_next = 1'b1;
            w_fsm_rst_next   = 1'b0;
            w_fail_next      = '0;
          end else begin
            w_fail_next = w_fail_inc;
            w_err_next  = 1'b1;
            if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
              w_state_next  = S_LOCKED;
              w_locked_next = 1'b1;
            end else begin
              w_state_next = S_ERROR;
            end
          end
        end
      end
      S_LOCKED: ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_fail      <= '0;
      r_shadow    <= '0;
      r_keyinput  <= '0;
      r_key_valid <= 1'b0;
      r_fsm_rst   <= 1'b1;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_busy      <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_fail      <= w_fail_next;
      r_shadow    <= w_shadow_next;
      r_keyinput  <= w_keyinput_next;
      r_key_valid <= w_key_valid_next;
      r_fsm_rst   <= w_fsm_rst_next;
      r_err       <= w_err_next;
      r_locked    <= w_locked_next;
      r_busy      <= w_busy_next;
      r_s_ready   <= w_s_ready_next;
    end
  end

  assign s_ready   = r_s_ready;
  assign keyinput  = r_keyinput;
  assign key_valid = r_key_valid;
  assign fsm_rst   = r_fsm_rst;
  assign err       = r_err;
  assign locked    = r_locked;
  assign busy      = r_busy;

endmodule

// File: tb/tb_key_stream_loader.sv
// Randomized self-checking bench for key_stream_loader against a load-level model.
module tb_key_stream_loader;

  localparam int KW   = 8;
  localparam int MAXF = 3;
  localparam int OW   = KW + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_data = 1'b0;
  logic          s_ready;
  logic [KW-1:0] keyinput;
  logic          key_valid, fsm_rst, err, locked, busy;

  int checks   = 0;
  int failures = 0;

  // Load-level model: what a finished load leaves on the outputs.
  logic [KW-1:0] m_key;
  logic          m_kv, m_fsm_rst, m_err, m_locked;
  int            m_fail;

  key_stream_loader #(.KEY_W(KW), .MAX_FAIL(MAXF)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .keyinput(keyinput), .key_valid(key_valid),
    .fsm_rst(fsm_rst), .err(err), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  // {keyinput, key_valid, fsm_rst, err, locked, busy, s_ready}
  function automatic logic [OW-1:0] obs();
    return {keyinput, key_valid, fsm_rst, err, locked, busy, s_ready};
  endfunction

  function automatic logic [OW-1:0] reset_vec();
    return {{KW{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [OW-1:0] model_vec();
    return {m_key, m_kv, m_fsm_rst, m_err, m_locked, 1'b0, 1'b0};
  endfunction

  function automatic logic [OW-1:0] model_e0_vec();
    return {m_key, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  endfunction

  task automatic model_reset();
    m_key = '0; m_kv = 1'b0; m_fsm_rst = 1'b1; m_err = 1'b0; m_locked = 1'b0; m_fail = 0;
  endtask

  task automatic model_load(input logic [KW-1:0] key, input logic par);
    if (((^key) ^ par) == 1'b0) begin
      m_key = key; m_kv = 1'b1; m_fsm_rst = 1'b0; m_err = 1'b0; m_fail = 0;
    end else begin
      m_kv = 1'b0; m_fsm_rst = 1'b1; m_err = 1'b1;
      if (m_fail < MAXF) m_fail++;
      m_locked = (m_fail == MAXF);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Pulses start, then streams key bits LSB first and the parity beat.
  // edges counts clock edges after the start edge up to the parity edge.
  task automatic run_load(input logic [KW-1:0] key, input logic par, input bit alt,
                          input bit mid_start, output logic [OW-1:0] snap_e0,
                          output int edges, output bit done);
    logic [KW:0] beats;
    int          idx;
    bit          phase, pulsed, acc;
    beats = {par, key}; idx = 0; edges = 0; phase = 1'b0; pulsed = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    snap_e0 = obs();
    while (idx <= KW && edges < 100) begin
      s_valid = !(alt && phase);
      s_data  = beats[idx];
      if (mid_start && !pulsed && idx == 4) begin
        start = 1'b1; pulsed = 1'b1;
      end
      acc = s_valid && s_ready;
      @(negedge clk);
      edges++; phase = !phase; start = 1'b0;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    done = (idx > KW);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs() !== reset_vec()) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", obs(), reset_vec());
    end
    // Beats offered while s_ready=0 are dropped.
    repeat (3) begin
      @(negedge clk); s_valid = 1'b1; s_data = 1'b1;
    end
    @(negedge clk); s_valid = 1'b0;
    checks++;
    if (obs() !== reset_vec()) begin
      failures++; $display("FAIL idle_beats_dropped got=%h exp=%h", obs(), reset_vec());
    end
  endtask

  task automatic test_good_load();
    logic [OW-1:0] snap; int edges; bit done;
    run_load(8'hA5, 1'b0, 1'b0, 1'b0, snap, edges, done);
    checks++;
    if (snap !== model_e0_vec()) begin
      failures++; $display("FAIL good_e0 got=%h exp=%h", snap, model_e0_vec());
    end
    model_load(8'hA5, 1'b0);
    checks++;
    if (!done || edges != KW + 1) begin
      failures++; $display("FAIL good_latency got=%0d exp=%0d done=%0d", edges, KW + 1, done);
    end
    checks++;
    if (obs() !== model_vec()) begin
      failures++; $display("FAIL good_armed got=%h exp=%h", obs(), model_vec());
    end
  endtask

  task automatic test_bad_then_good();
    logic [OW-1:0] snap; int edges; bit done;
    apply_reset();
    run_load(8'hA5, 1'b1, 1'b0, 1'b0, snap, edges, done);
    model_load(8'hA5, 1'b1);
    checks++;
    if (!done || obs() !== model_vec()) begin
      failures++; $display("FAIL bad_no_prior got=%h exp=%h", obs(), model_vec());
    end
    run_load(8'h3C, 1'b0, 1'b0, 1'b0, snap, edges, done);
    checks++;
    if (snap !== model_e0_vec()) begin
      failures++; $display("FAIL reload_e0 got=%h exp=%h", snap, model_e0_vec());
    end
    model_load(8'h3C, 1'b0);
    checks++;
    if (!done || obs() !== model_vec()) begin
      failures++; $display("FAIL reload_armed got=%h exp=%h", obs(), model_vec());
    end
  endtask

  task automatic test_keep_old_key();
    logic [OW-1:0] snap; int edges; bit done;
    apply_reset();
    run_load(8'hA5, 1'b0, 1'b0, 1'b0, snap, edges, done);
    model_load(8'hA5, 1'b0);
    run_load(8'h0F, 1'b1, 1'b0, 1'b0, snap, edges, done);
    checks++;
    if (snap !== model_e0_vec()) begin
      failures++; $display("FAIL rearm_e0 got=%h exp=%h", snap, model_e0_vec());
    end
    model_load(8'h0F, 1'b1);
    checks++;
    if (!done || obs() !== model_vec()) begin
      failures++; $display("FAIL keep_old_key got=%h exp=%h", obs(), model_vec());
    end
  endtask

  task automatic test_lockout();
    logic [OW-1:0] snap; int edges; bit done;
    logic [KW-1:0] key;
    apply_reset();
    for (int i = 0; i < MAXF; i++) begin
      key = KW'($urandom);
      run_load(key, ~(^key), 1'b0, 1'b0, snap, edges, done);
      model_load(key, ~(^key));
      checks++;
      if (!done || obs() !== model_vec()) begin
        failures++; $display("FAIL lockout_load%0d got=%h exp=%h", i, obs(), model_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || s_ready !== 1'b0) begin
      failures++; $display("FAIL locked_flags got=%b%b exp=10", locked, s_ready);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 1'b1;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (obs() !== model_vec()) begin
      failures++; $display("FAIL locked_ignores_start got=%h exp=%h", obs(), model_vec());
    end
    apply_reset();
    checks++;
    if (obs() !== reset_vec()) begin
      failures++; $display("FAIL unlock_by_rst got=%h exp=%h", obs(), reset_vec());
    end
  endtask

  task automatic test_stall_mid_start();
    logic [OW-1:0] snap; int edges; bit done;
    apply_reset();
    run_load(8'h81, 1'b0, 1'b1, 1'b1, snap, edges, done);
    model_load(8'h81, 1'b0);
    checks++;
    if (!done || edges != 2 * (KW + 1) - 1) begin
      failures++; $display("FAIL stall_latency got=%0d exp=%0d", edges, 2 * (KW + 1) - 1);
    end
    checks++;
    if (obs() !== model_vec()) begin
      failures++; $display("FAIL stall_armed got=%h exp=%h", obs(), model_vec());
    end
  endtask

  task automatic test_rst_midload();
    logic [OW-1:0] snap; int edges; bit done;
    apply_reset();
    run_load(8'h5A, 1'b0, 1'b0, 1'b0, snap, edges, done);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = i[0];
      @(negedge clk);
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== reset_vec()) begin
      failures++; $display("FAIL rst_async got=%h exp=%h", obs(), reset_vec());
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    run_load(8'hFF, 1'b0, 1'b0, 1'b0, snap, edges, done);
    model_load(8'hFF, 1'b0);
    checks++;
    if (!done || obs() !== model_vec()) begin
      failures++; $display("FAIL post_rst_load got=%h exp=%h", obs(), model_vec());
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] snap; int edges, exp_edges; bit done, alt, mid;
    logic [KW-1:0] key; logic par;
    apply_reset();
    for (int n = 0; n < 24; n++) begin
      if (m_locked) apply_reset();
      key = KW'($urandom);
      par = ($urandom_range(0, 2) == 0) ? ~(^key) : (^key);
      alt = 1'($urandom);
      mid = 1'($urandom);
      exp_edges = alt ? 2 * (KW + 1) - 1 : KW + 1;
      run_load(key, par, alt, mid, snap, edges, done);
      checks++;
      if (snap !== model_e0_vec()) begin
        failures++; $display("FAIL rand%0d_e0 got=%h exp=%h", n, snap, model_e0_vec());
      end
      model_load(key, par);
      checks++;
      if (!done || edges != exp_edges) begin
        failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, edges, exp_edges);
      end
      checks++;
      if (obs() !== model_vec()) begin
        failures++; $display("FAIL rand%0d_out got=%h exp=%h", n, obs(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_load();
    test_bad_then_good();
    test_keep_old_key();
    test_lockout();
    test_stall_mid_start();
    test_rst_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_stream_loader.md
# key_stream_loader

Upstream key-delivery stage for the key-locked controller FSM benchmarks. It receives a serial key stream over a valid/ready handshake and checks an even-parity beat. It then presents the accepted key as a stable parallel `keyinput` bus and holds the downstream FSM in reset until a valid key is armed. Repeated bad loads lock the block until reset.

## Interface
Parameters:
- `KEY_W`, default 8: number of key bits driven to the downstream FSM (≥1).
- `MAX_FAIL`, default 3: consecutive parity failures that force LOCKED (≥1).

Ports:
- `clk`, in, 1: clock; all state updates on posedge.
- `rst`, in, 1: reset; asynchronous, active-high.
- `start`, in, 1: begin a (re)load; one-cycle pulse.
- `s_valid`, in, 1: serial beat valid.
- `s_data`, in, 1: serial beat; key bits LSB first, then one parity beat.
- `s_ready`, out, 1: block accepts a beat this cycle.
- `keyinput`, out, KEY_W: armed key, parallel to the downstream FSM.
- `key_valid`, out, 1: `keyinput` holds a parity-checked key.
- `fsm_rst`, out, 1: active-high reset for the downstream FSM.
- `err`, out, 1: last load failed parity.
- `locked`, out, 1: MAX_FAIL consecutive failures; only `rst` clears.
- `busy`, out, 1: load in progress (SHIFT or PARITY).

## Operation
- States: IDLE, SHIFT, PARITY, ARMED, ERROR, LOCKED.
- Reset values: state=IDLE, `keyinput`=0, shadow shift register=0, bit counter=0, fail counter=0, `key_valid`=0, `fsm_rst`=1, `err`=0, `locked`=0, `busy`=0, `s_ready`=0.
- IDLE/ARMED/ERROR + `start`=1 → SHIFT:
  - Clears the bit counter, the shadow register and `err`.
  - Drops `key_valid` and asserts `fsm_rst`.
  - `keyinput` holds its old value.
- SHIFT:
  - `s_ready`=1. Each accepted beat (`s_valid && s_ready`) writes `s_data` into shadow bit [count], then count+1.
  - After beat KEY_W-1 is accepted → PARITY.
- PARITY: `s_ready`=1. On the accepted beat, compute p = XOR(shadow) ^ `s_data`.
  - p=0 → ARMED: `keyinput`←shadow, `key_valid`=1, `fsm_rst`=0, fail counter←0.
  - p=1 → fail counter+1. If the new count equals MAX_FAIL → LOCKED, else → ERROR. `err`=1 in both cases.
- ARMED: outputs stable; only `start` leaves this state.
- ERROR: `fsm_rst`=1, `key_valid`=0; `keyinput` retains the last armed key (0 if none).
- LOCKED: `locked`=1, `err`=1, `fsm_rst`=1, `s_ready`=0; `start` is ignored.
- Boundary conditions:
  - `start` during SHIFT/PARITY: ignored; the load continues.
  - `s_valid` while `s_ready`=0: beat dropped, no state change.
  - `s_valid` stalls inside SHIFT/PARITY: wait indefinitely; no timeout.
  - `rst` mid-load: immediate return to reset values; a partial key is never exposed.
- Counter width is clog2(KEY_W+1). The fail counter saturates at MAX_FAIL.

## Timing
- All outputs are registered; `fsm_rst` is glitch-free.
- `start` sampled at edge E0: `busy`=1, `s_ready`=1, `fsm_rst`=1, `key_valid`=0 are visible after E0.
- With continuous `s_valid`, key bits are accepted at E1..E_KEY_W and the parity beat at E_(KEY_W+1). The ARMED outputs (`keyinput`, `key_valid`=1, `fsm_rst`=0, `busy`=0) update together after that edge. Minimum load latency is KEY_W+1 cycles after the `start` edge.
- `keyinput` changes only on the same edge that deasserts `fsm_rst`. The downstream FSM samples on negedge, which gives half a cycle of setup margin.
- `err` and `locked` update on the parity edge.

## Test plan
- Reset, then load KEY_W=8 key 0xA5: beats 1,0,1,0,0,1,0,1 then parity 0 → after beat 9: `keyinput`=0xA5, `key_valid`=1, `fsm_rst`=0, `err`=0.
- Same load with parity 1 → ERROR: `err`=1, `fsm_rst`=1, `keyinput`=0 (no prior key); then reload 0x3C with parity 0 → ARMED, `err`=0.
- Arm 0xA5, then `start` and load 0x0F with bad parity → `keyinput` stays 0xA5, `key_valid`=0, `fsm_rst`=1.
- MAX_FAIL=3: three consecutive bad loads → `locked`=1, `s_ready`=0; a further `start` is ignored; `rst` → IDLE, `locked`=0.
- `s_valid` toggled every other cycle during a 0x81 load; `start` pulsed mid-SHIFT → key still 0x81, armed 17 edges after start.
- Assert `rst` after 4 beats → all outputs at reset values immediately; a following full load of 0xFF with parity 0 arms correctly.
